// File: rtl/binary_morph.sv
// Streaming binary dilation/erosion over a KxK window.
// Line buffer holds K-1 rows; outside-image taps are masked as neutral.
module binary_morph #(
   parameter int DATA_WIDTH  = 8,
   parameter int IMG_WIDTH   = 10,
   parameter int IMG_HEIGHT  = 4,
   parameter int KERNEL_SIZE = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] pixel_in,
   input  logic                  pixel_in_valid,
   output logic                  pixel_in_ready,
   input  logic                  mode,
   input  logic                  border_clear,
   output logic [DATA_WIDTH-1:0] pixel_out,
   output logic                  pixel_out_valid,
   output logic                  frame_done
);

   localparam int R  = (KERNEL_SIZE - 1) / 2;
   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);
   localparam int NF = R * IMG_WIDTH + R;
   localparam int FW = $clog2(NF + 1);

   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [XW-1:0] X_R    = XW'(R);
   localparam logic [XW-1:0] X_HI   = XW'(IMG_WIDTH - R);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
   localparam logic [YW-1:0] Y_R    = YW'(R);
   localparam logic [YW-1:0] Y_HI   = YW'(IMG_HEIGHT - R);
   localparam logic [FW-1:0] F_INIT = FW'(NF);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } state_t;

   state_t                  r_state;
   logic                    r_ready;
   logic [XW-1:0]           r_ix;
   logic [YW-1:0]           r_iy;
   logic [XW-1:0]           r_ox;
   logic [YW-1:0]           r_oy;
   logic [FW-1:0]           r_fcnt;
   logic                    r_mode;
   logic                    r_bclr;
   logic                    r_s1_valid;
   logic [XW-1:0]           r_s1_x;
   logic [YW-1:0]           r_s1_y;
   logic                    r_s1_last;
   logic [DATA_WIDTH-1:0]   r_out;
   logic                    r_out_valid;
   logic                    r_done;

   logic [KERNEL_SIZE-2:0]  r_lb  [IMG_WIDTH];
   logic [KERNEL_SIZE-1:0]  r_win [KERNEL_SIZE];

   logic                    w_acc;
   logic                    w_fstep;
   logic                    w_step;
   logic                    w_bit;
   logic                    w_primed;
   logic                    w_last_in;
   logic [KERNEL_SIZE-1:0]  w_col;
   logic [KERNEL_SIZE-1:0]  w_colok;
   logic [KERNEL_SIZE-1:0]  w_rowok;
   logic                    w_any;
   logic                    w_all;
   logic                    w_border;
   logic                    w_res;

   assign w_acc     = pixel_in_valid & r_ready;
   assign w_fstep   = (r_state == FLUSH) && (r_fcnt != '0);
   assign w_step    = w_acc | w_fstep;
   // Flush steps push zero columns; those rows lie below the image and are masked.
   assign w_bit     = w_acc & (|pixel_in);
   assign w_col     = {w_bit, r_lb[r_ix]};
   assign w_last_in = w_acc && (r_ix == X_LAST) && (r_iy == Y_LAST);
   assign w_primed  = (r_state == FLUSH) || (r_iy > Y_R)
                      || ((r_iy == Y_R) && (r_ix >= X_R));

   always_ff @(posedge clk) begin
      if (w_step) begin
         r_lb[r_ix] <= w_col[KERNEL_SIZE-1:1];
      end
   end

   always_ff @(posedge clk) begin
      if (w_step) begin
         for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
            r_win[j] <= r_win[j+1];
         end
         r_win[KERNEL_SIZE-1] <= w_col;
      end
   end

   // Column j is offset j-R from the centre; row bit i is offset i-R.
   always_comb begin
      w_colok = '0;
      w_rowok = '0;
      w_any   = 1'b0;
      w_all   = 1'b1;
      for (int j = 0; j < KERNEL_SIZE; j++) begin
         w_colok[j] = (int'(r_s1_x) + j >= R)
                      && (int'(r_s1_x) + j < IMG_WIDTH + R);
         w_rowok[j] = (int'(r_s1_y) + j >= R)
                      && (int'(r_s1_y) + j < IMG_HEIGHT + R);
      end
      for (int j = 0; j < KERNEL_SIZE; j++) begin
         for (int i = 0; i < KERNEL_SIZE; i++) begin
            if (w_colok[j] && w_rowok[i]) begin
               w_any = w_any | r_win[j][i];
               w_all = w_all & r_win[j][i];
            end
         end
      end
   end

   assign w_border = (r_s1_x < X_R) || (r_s1_x >= X_HI)
                     || (r_s1_y < Y_R) || (r_s1_y >= Y_HI);
   assign w_res    = (r_bclr && w_border) ? 1'b0
                     : (r_mode ? w_all : w_any);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ready     <= 1'b0;
         r_ix        <= '0;
         r_iy        <= '0;
         r_ox        <= '0;
         r_oy        <= '0;
         r_fcnt      <= '0;
         r_mode      <= 1'b0;
         r_bclr      <= 1'b0;
         r_s1_valid  <= 1'b0;
         r_s1_x      <= '0;
         r_s1_y      <= '0;
         r_s1_last   <= 1'b0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         if (w_step) begin
            if (r_ix == X_LAST) begin
               r_ix <= '0;
               r_iy <= (r_iy == Y_LAST) ? '0 : r_iy + 1'b1;
            end else begin
               r_ix <= r_ix + 1'b1;
            end
         end

         r_s1_valid <= w_step && w_primed;
         if (w_step && w_primed) begin
            r_s1_x    <= r_ox;
            r_s1_y    <= r_oy;
            r_s1_last <= (r_ox == X_LAST) && (r_oy == Y_LAST);
            if (r_ox == X_LAST) begin
               r_ox <= '0;
               r_oy <= (r_oy == Y_LAST) ? '0 : r_oy + 1'b1;
            end else begin
               r_ox <= r_ox + 1'b1;
            end
         end

         r_out_valid <= r_s1_valid;
         r_out       <= (r_s1_valid && w_res) ? '1 : '0;
         r_done      <= r_s1_valid && r_s1_last;

         unique case (r_state)
            IDLE: begin
               r_ready <= 1'b1;
               if (w_acc) begin
                  r_state <= RUN;
                  r_mode  <= mode;
                  r_bclr  <= border_clear;
               end
            end
            RUN: begin
               if (w_last_in) begin
                  r_state <= FLUSH;
                  r_ready <= 1'b0;
                  r_fcnt  <= F_INIT;
               end
            end
            FLUSH: begin
               if (w_fstep) begin
                  r_fcnt <= r_fcnt - 1'b1;
               end
               if (r_done) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
                  r_ix    <= '0;
                  r_iy    <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign pixel_in_ready  = r_ready;
   assign pixel_out       = r_out;
   assign pixel_out_valid = r_out_valid;
   assign frame_done      = r_done;

endmodule

// File: doc/binary_morph.md
BINARY_MORPH -- requirements
Module: binary_morph

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the pixel width in bits.
REQ-002 The block SHALL have parameter IMG_WIDTH, default 10, giving pixels per line; legal when IMG_WIDTH > KERNEL_SIZE.
REQ-003 The block SHALL have parameter IMG_HEIGHT, default 4, giving lines per frame; legal when IMG_HEIGHT > KERNEL_SIZE.
REQ-004 The block SHALL have parameter KERNEL_SIZE, default 3, giving the square window side; legal values are 3, 5 and 7. R = (KERNEL_SIZE-1)/2.
REQ-005 The block SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port pixel_in, input, DATA_WIDTH bits: raster-order input pixel.
REQ-008 The block SHALL have port pixel_in_valid, input, 1 bit: pixel_in is presented.
REQ-009 The block SHALL have port pixel_in_ready, output, 1 bit: the block can accept a pixel. A pixel is accepted when valid and ready are both 1.
REQ-010 The block SHALL have port mode, input, 1 bit: 0 selects dilation, 1 selects erosion.
REQ-011 The block SHALL have port border_clear, input, 1 bit: 1 forces edge-ring outputs to 0.
REQ-012 The block SHALL have port pixel_out, output, DATA_WIDTH bits: morphology result, all-zeros or all-ones.
REQ-013 The block SHALL have port pixel_out_valid, output, 1 bit: pixel_out is valid. There is no output backpressure.
REQ-014 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the last output pixel of a frame.

Function
REQ-015 An input pixel SHALL be binarised to 1 if it is nonzero and to 0 otherwise.
REQ-016 The line buffer SHALL be internal and hold KERNEL_SIZE-1 lines; it is inferred as RAM.
REQ-017 The FSM SHALL have states IDLE, RUN and FLUSH, and SHALL reset to IDLE.
REQ-018 The FSM SHALL move from IDLE to RUN on acceptance of pixel (0,0), and from RUN to FLUSH on acceptance of pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
REQ-019 The FSM SHALL move from FLUSH to IDLE in the cycle after frame_done.
REQ-020 pixel_in_ready SHALL be 1 in IDLE and RUN and 0 in FLUSH.
REQ-021 mode and border_clear SHALL be sampled on acceptance of pixel (0,0) and held for the whole frame; changes mid-frame SHALL be ignored.
REQ-022 Output pixel index i (raster order, 0 to W*H-1) SHALL depend on input index k = i + R*IMG_WIDTH + R.
REQ-023 If k < W*H, pixel_out_valid for index i SHALL assert exactly 2 cycles after input k is accepted.
REQ-024 If k ≥ W*H, output index i SHALL be emitted in FLUSH at one per cycle with no gaps, so that output-valid cycles are contiguous, the first immediately following output W*H-1-R*IMG_WIDTH-R in the 2-cycle pipeline.
REQ-025 Cycles with pixel_in_valid=0 SHALL stall the pipeline; no output is produced for an input that is not accepted.
REQ-026 Exactly IMG_WIDTH*IMG_HEIGHT outputs SHALL be produced per frame.
REQ-027 Window positions outside the image SHALL be neutral: treated as 0 for dilation and as 1 for erosion.
REQ-028 In dilation mode, the output SHALL be all-ones if any window bit is 1.
REQ-029 In erosion mode, the output SHALL be all-ones only if all window bits are 1.
REQ-030 If border_clear=1, any output with x<R, x≥IMG_WIDTH-R, y<R or y≥IMG_HEIGHT-R SHALL be all-zeros.
REQ-031 The x/y output counters SHALL wrap at IMG_WIDTH-1 / IMG_HEIGHT-1 and SHALL be sized with $clog2 of the respective dimension.
REQ-032 Back-to-back frames SHALL be supported: the next pixel (0,0) is accepted from the cycle after the FSM returns to IDLE.

Reset
REQ-033 On rst=1 the block SHALL force pixel_out=0, pixel_out_valid=0, frame_done=0, pixel_in_ready=0 and state=IDLE, and SHALL clear all counters.
REQ-034 pixel_in_ready SHALL go to 1 in the first cycle after rst deasserts.
REQ-035 A reset applied mid-frame SHALL discard the partial frame; line-buffer contents need not be cleared, because neutral padding masks stale data.

Verification
REQ-036 Dilation point test (W=8, H=6, K=3, mode=0, single 0x01 at (3,3)): outputs (2..4, 2..4) = 0xFF (9 pixels), others 0x00; 48 outputs total; one frame_done pulse.
REQ-037 Erosion border test (all-0xFF frame, mode=1): with border_clear=0, all 48 outputs = 0xFF; with border_clear=1, the outer ring = 0x00 and the 24 interior pixels = 0xFF.
REQ-038 Latency test: the first pixel_out_valid SHALL occur 2 cycles after acceptance of input index 9 (R*W+R); with valid toggling 1/0, outputs SHALL be spaced 2 cycles apart.
REQ-039 Flush test: after the last input, pixel_in_ready=0; 9 outputs are emitted contiguously with frame_done on the 9th; ready=1 the following cycle; an immediate second frame produces identical results.
REQ-040 Sampling and reset test: toggling mode mid-frame SHALL not change results; asserting rst at input index 20 SHALL drop valid and ready the next cycle, after which a fresh frame SHALL produce the correct 48 outputs.
